// File: rtl/core_types_pkg.sv
// -----------------------------------------------------------------------------
// core_types_pkg
// Shared rename-stage types: architectural / physical register tags, ROB
// indices, checkpoint columns and the whole-map snapshot type.
// -----------------------------------------------------------------------------
package core_types_pkg;

   localparam int NUM_ARCH_REGS   = 32;
   localparam int NUM_PHYS_REGS   = 64;
   localparam int NUM_ROB_ENTRIES = 64;
   // Must stay a power of two: column arithmetic relies on natural wrap.
   localparam int NUM_CHECKPOINTS = 4;

   typedef logic [$clog2(NUM_ARCH_REGS)-1:0]   arch_reg_tag_t;
   typedef logic [$clog2(NUM_PHYS_REGS)-1:0]   phys_reg_tag_t;
   typedef logic [$clog2(NUM_ROB_ENTRIES)-1:0] ROB_index_t;
   typedef logic [$clog2(NUM_CHECKPOINTS)-1:0] checkpoint_column_t;

   // Whole rename map, indexed by architectural register.
   typedef phys_reg_tag_t [NUM_ARCH_REGS-1:0] map_snapshot_t;

   // Age of a column relative to the oldest live checkpoint (head = age 0).
   function automatic checkpoint_column_t column_age(input checkpoint_column_t col,
                                                     input checkpoint_column_t head);
      return col - head;
   endfunction

endpackage

// File: rtl/reg_map_checkpoint_buffer.sv
// -----------------------------------------------------------------------------
// reg_map_checkpoint_buffer
// Circular buffer of rename-map snapshots for single-cycle branch recovery.
// Entries are allocated at tail and retired from head; a failed speculation
// rolls tail back to the restored column, killing it and everything younger.
//
// Ports:
//   i_clk, i_rst_n               clock, async active-low reset
//   i_map                        current registered rename map (snapshot source)
//   i_save_valid/_rob_index      request a new checkpoint
//   o_save_success/_column       allocation handshake (column is always tail)
//   i_restore_valid              request a restore
//   i_restore_speculate_failed   1: roll back map, 0: retire head checkpoint
//   i_restore_rob_index/_column  identify the checkpoint
//   o_restore_success            restore accepted
//   o_restore_map_load           accepted restore that must reload the map
//   o_restore_snapshot           snapshot stored in i_restore_column
// -----------------------------------------------------------------------------
module reg_map_checkpoint_buffer
   import core_types_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  map_snapshot_t      i_map,
   input  logic               i_save_valid,
   input  ROB_index_t         i_save_rob_index,
   output logic               o_save_success,
   output checkpoint_column_t o_save_column,
   input  logic               i_restore_valid,
   input  logic               i_restore_speculate_failed,
   input  ROB_index_t         i_restore_rob_index,
   input  checkpoint_column_t i_restore_column,
   output logic               o_restore_success,
   output logic               o_restore_map_load,
   output map_snapshot_t      o_restore_snapshot
);

   logic [NUM_CHECKPOINTS-1:0] r_valid;
   ROB_index_t                 r_rob_index [NUM_CHECKPOINTS];
   map_snapshot_t              r_snapshot  [NUM_CHECKPOINTS];
   checkpoint_column_t         r_head;
   checkpoint_column_t         r_tail;

   logic                       w_restore_hit;
   logic                       w_restore_fail;
   logic                       w_restore_commit;
   logic                       w_save_ok;
   checkpoint_column_t         w_restore_age;
   logic [NUM_CHECKPOINTS-1:0] w_kill;

   // A correct-speculation restore may only retire the oldest checkpoint.
   assign w_restore_hit    = i_restore_valid
                          && r_valid[i_restore_column]
                          && (r_rob_index[i_restore_column] == i_restore_rob_index)
                          && (i_restore_speculate_failed || (i_restore_column == r_head));
   assign w_restore_fail   = w_restore_hit &&  i_restore_speculate_failed;
   assign w_restore_commit = w_restore_hit && !i_restore_speculate_failed;

   // A rollback moves tail, so a same-cycle save is dropped.
   assign w_save_ok = i_save_valid && !r_valid[r_tail] && !w_restore_fail;

   assign o_save_success     = w_save_ok;
   assign o_save_column      = r_tail;
   assign o_restore_success  = w_restore_hit;
   assign o_restore_map_load = w_restore_fail;
   assign o_restore_snapshot = r_snapshot[i_restore_column];

   // Kill every entry at least as young as the restored column. Measuring
   // age from head also covers the full-buffer case where tail == column.
   assign w_restore_age = column_age(i_restore_column, r_head);

   // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_kill = '0;
      for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
         w_kill[i] = (column_age(checkpoint_column_t'(i), r_head) >= w_restore_age);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; blocking ones would race between always blocks.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
            r_rob_index[i] <= '0;
         end
      end else if (w_restore_fail) begin
         r_valid <= r_valid & ~w_kill;
         r_tail  <= i_restore_column;
      end else begin
         // Save and retire never touch the same entry: retire needs head valid,
         // save needs tail invalid, and head == tail with head valid means full.
         if (w_save_ok) begin
            r_valid[r_tail]     <= 1'b1;
            r_rob_index[r_tail] <= i_save_rob_index;
            r_tail              <= r_tail + 1'b1;
         end
         if (w_restore_commit) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
      end
   end

   // NOTE: snapshot storage is deliberately not reset; the valid bits gate every use of it.
   always_ff @(posedge i_clk) begin
      if (w_save_ok) begin
         r_snapshot[r_tail] <= i_map;
      end
   end

endmodule

// File: rtl/reg_map_table.sv
// -----------------------------------------------------------------------------
// reg_map_table
// Architectural-to-physical register map for the rename stage. Two source
// read ports plus the old-dest read are combinational from the registered map
// (no same-cycle bypass). Dispatch writes new dest mappings, ROB reverts walk
// mappings back, and a checkpoint buffer provides single-cycle branch recovery.
//
// Ports:
//   CLK, nRST                            clock, async active-low reset
//   source_arch_reg_tag_A/B              rename source lookups
//   source_phys_reg_tag_A/B              their mappings
//   dispatch_valid/_dest_arch/_dest_phys new dest mapping
//   dispatch_old_dest_phys_reg_tag       current mapping of dispatch dest
//   revert_valid/_dest_arch/_safe_phys   ROB tail walk-back
//   save_checkpoint_*                    checkpoint allocation handshake
//   restore_checkpoint_*                 checkpoint restore / retire handshake
// -----------------------------------------------------------------------------
module reg_map_table
   import core_types_pkg::*;
(
   input  logic               CLK,
   input  logic               nRST,
   input  arch_reg_tag_t      source_arch_reg_tag_A,
   output phys_reg_tag_t      source_phys_reg_tag_A,
   input  arch_reg_tag_t      source_arch_reg_tag_B,
   output phys_reg_tag_t      source_phys_reg_tag_B,
   input  logic               dispatch_valid,
   input  arch_reg_tag_t      dispatch_dest_arch_reg_tag,
   input  phys_reg_tag_t      dispatch_dest_phys_reg_tag,
   output phys_reg_tag_t      dispatch_old_dest_phys_reg_tag,
   input  logic               revert_valid,
   input  arch_reg_tag_t      revert_dest_arch_reg_tag,
   input  phys_reg_tag_t      revert_safe_dest_phys_reg_tag,
   input  logic               save_checkpoint_valid,
   input  ROB_index_t         save_checkpoint_ROB_index,
   output logic               save_checkpoint_success,
   output checkpoint_column_t save_checkpoint_column,
   input  logic               restore_checkpoint_valid,
   input  logic               restore_checkpoint_speculate_failed,
   input  ROB_index_t         restore_checkpoint_ROB_index,
   input  checkpoint_column_t restore_checkpoint_column,
   output logic               restore_checkpoint_success
);

   map_snapshot_t r_map;
   map_snapshot_t w_restore_snapshot;
   logic          w_restore_map_load;

   // Arch 0 is hardwired to phys 0 regardless of map contents.
   assign source_phys_reg_tag_A = (source_arch_reg_tag_A == '0) ? '0 : r_map[source_arch_reg_tag_A];
   assign source_phys_reg_tag_B = (source_arch_reg_tag_B == '0) ? '0 : r_map[source_arch_reg_tag_B];
   assign dispatch_old_dest_phys_reg_tag =
      (dispatch_dest_arch_reg_tag == '0) ? '0 : r_map[dispatch_dest_arch_reg_tag];

   reg_map_checkpoint_buffer u_checkpoint_buffer (
      .i_clk                      (CLK),
      .i_rst_n                    (nRST),
      .i_map                      (r_map),
      .i_save_valid               (save_checkpoint_valid),
      .i_save_rob_index           (save_checkpoint_ROB_index),
      .o_save_success             (save_checkpoint_success),
      .o_save_column              (save_checkpoint_column),
      .i_restore_valid            (restore_checkpoint_valid),
      .i_restore_speculate_failed (restore_checkpoint_speculate_failed),
      .i_restore_rob_index        (restore_checkpoint_ROB_index),
      .i_restore_column           (restore_checkpoint_column),
      .o_restore_success          (restore_checkpoint_success),
      .o_restore_map_load         (w_restore_map_load),
      .o_restore_snapshot         (w_restore_snapshot)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            r_map[i] <= phys_reg_tag_t'(i);
         end
      end else if (w_restore_map_load) begin
         r_map <= w_restore_snapshot;
      end else begin
         if (dispatch_valid && (dispatch_dest_arch_reg_tag != '0)) begin
            r_map[dispatch_dest_arch_reg_tag] <= dispatch_dest_phys_reg_tag;
         end
         // Placed after dispatch so revert wins on the same arch reg.
         if (revert_valid && (revert_dest_arch_reg_tag != '0)) begin
            r_map[revert_dest_arch_reg_tag] <= revert_safe_dest_phys_reg_tag;
         end
      end
   end

endmodule
